// File: rtl/inst_fetch_bus_if_if.sv
// Wishbone classic read-only instruction bus used by the fetch responder.
// master: the fetch unit driving the bus; slave: the instruction memory side.
interface inst_fetch_bus_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [3:0]        wb_sel_o;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/inst_fetch_bus_if.sv
// Instruction-fetch responder: turns each enabled pc into one Wishbone classic read,
// stalls the pipeline until the word arrives, and honours stall, flush and branch squash.
module inst_fetch_bus_if #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] NOP_INST    = '0,
  parameter int                ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              branch_flush_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_err_o,
  inst_fetch_bus_if_if.master wb
);

  localparam int ACK_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [ACK_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? ACK_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [ACK_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] adr_reg, adr_next;
  logic [DATA_W-1:0] rd_buf_reg, rd_buf_next;
  logic [ACK_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] ack_data;
  logic              timeout;

  // A squashed word is replaced by NOP both on the bus-return cycle and in the buffer.
  assign ack_data = branch_flush_i ? NOP_INST : wb.wb_dat_i;
  assign timeout  = (ACK_TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      adr_reg    <= '0;
      rd_buf_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      adr_reg    <= adr_next;
      rd_buf_reg <= rd_buf_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    adr_next    = adr_reg;
    rd_buf_next = rd_buf_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          adr_next   = cpu_addr_i;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_next = IDLE;
        end else if (wb.wb_ack_i) begin
          rd_buf_next = ack_data;
          state_next  = (stall_i != 6'd0) ? WAIT_STALL : IDLE;
        end else if (timeout) begin
          state_next = IDLE;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_STALL: begin
        if (flush_i) begin
          state_next  = IDLE;
          rd_buf_next = NOP_INST;
        end else if (stall_i == 6'd0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced to their idle values while reset is asserted.
  always_comb begin
    cpu_data_o = NOP_INST;
    stallreq_o = 1'b0;
    bus_err_o  = 1'b0;
    if (rst) begin
      case (state_reg)
        IDLE: stallreq_o = cpu_ce_i && !flush_i;
        BUSY: begin
          if (!flush_i) begin
            if (wb.wb_ack_i) begin
              cpu_data_o = ack_data;
            end else if (timeout) begin
              bus_err_o = 1'b1;
            end else begin
              stallreq_o = 1'b1;
            end
          end
        end
        WAIT_STALL: cpu_data_o = rd_buf_reg;
        default: cpu_data_o = NOP_INST;
      endcase
    end
  end

  assign wb.wb_cyc_o = (state_reg == BUSY);
  assign wb.wb_stb_o = (state_reg == BUSY);
  assign wb.wb_adr_o = adr_reg;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = (state_reg == BUSY) ? 4'b1111 : 4'b0000;

endmodule
